// File: rtl/round_ctrl.sv
// Iterative round sequencer: loads a 32-bit block and key vector, drives an external
// combinational round function once per cycle for NUM_ROUNDS rounds, then pulses DONE.
module round_ctrl #(
  parameter int NUM_ROUNDS = 16,
  parameter int KEY_WIDTH  = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [31:0]          D_IN,
  input  logic [KEY_WIDTH-1:0] KEY,
  output logic [31:0]          ROUND_D,
  output logic [7:0]           ROUND_K,
  input  logic [31:0]          ROUND_Q,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [31:0]          D_OUT,
  output logic [1:0]           o_dbg_fsm
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } fsm_t;

  localparam logic [7:0] LAST_CNT = 8'(NUM_ROUNDS - 1);

  fsm_t                 r_fsm;
  fsm_t                 w_fsm_nxt;
  logic [31:0]          r_state;
  logic [KEY_WIDTH-1:0] r_key;
  logic [KEY_WIDTH-1:0] w_key_rot;
  logic [7:0]           r_cnt;
  logic [31:0]          r_dout;
  logic                 r_done;
  logic                 w_load;
  logic                 w_step;
  logic                 w_final;

  // Rotating right by one byte brings the next round's key byte into [7:0].
  generate
    if (KEY_WIDTH == 8) begin : g_key_single
      assign w_key_rot = r_key;
    end else begin : g_key_multi
      assign w_key_rot = {r_key[7:0], r_key[KEY_WIDTH-1:8]};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_final   = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (START) begin
          w_load    = 1'b1;
          w_fsm_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_final   = 1'b1;
          w_fsm_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_fsm_nxt = S_IDLE;
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= '0;
      r_key   <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_final;
      if (w_load) begin
        r_state <= D_IN;
        r_key   <= KEY;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_state <= ROUND_Q;
        r_key   <= w_key_rot;
        r_cnt   <= r_cnt + 8'd1;
      end
      // Result register only changes on the final round edge.
      if (w_final) begin
        r_dout <= ROUND_Q;
      end
    end
  end

  assign ROUND_D   = r_state;
  assign ROUND_K   = r_key[7:0];
  assign BUSY      = (r_fsm != S_IDLE);
  assign DONE      = r_done;
  assign D_OUT     = r_dout;
  assign o_dbg_fsm = r_fsm;

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: three instances (1 round, 16 rounds, 8-bit key) with a
// byte-rotate-xor round function model and per-instance expected-result queues.
module tb_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance signals ----------------
  logic        start1, busy1, done1;
  logic [31:0] d1, rd1, rq1, dout1;
  logic [63:0] k1;
  logic [7:0]  rk1;
  logic [1:0]  fsm1;

  logic        start16, busy16, done16;
  logic [31:0] d16, rd16, rq16, dout16;
  logic [63:0] k16;
  logic [7:0]  rk16;
  logic [1:0]  fsm16;

  logic        start8, busy8, done8;
  logic [31:0] d8, rd8, rq8, dout8;
  logic [7:0]  k8;
  logic [7:0]  rk8;
  logic [1:0]  fsm8;

  assign rq1  = {rd1[23:0],  rd1[31:24]}  ^ {24'h0, rk1};
  assign rq16 = {rd16[23:0], rd16[31:24]} ^ {24'h0, rk16};
  assign rq8  = {rd8[23:0],  rd8[31:24]}  ^ {24'h0, rk8};

  round_ctrl #(.NUM_ROUNDS(1), .KEY_WIDTH(64)) u1 (
    .CLK(clk), .RST(rst), .START(start1), .D_IN(d1), .KEY(k1),
    .ROUND_D(rd1), .ROUND_K(rk1), .ROUND_Q(rq1),
    .BUSY(busy1), .DONE(done1), .D_OUT(dout1), .o_dbg_fsm(fsm1));

  round_ctrl #(.NUM_ROUNDS(16), .KEY_WIDTH(64)) u16 (
    .CLK(clk), .RST(rst), .START(start16), .D_IN(d16), .KEY(k16),
    .ROUND_D(rd16), .ROUND_K(rk16), .ROUND_Q(rq16),
    .BUSY(busy16), .DONE(done16), .D_OUT(dout16), .o_dbg_fsm(fsm16));

  round_ctrl #(.NUM_ROUNDS(5), .KEY_WIDTH(8)) u8 (
    .CLK(clk), .RST(rst), .START(start8), .D_IN(d8), .KEY(k8),
    .ROUND_D(rd8), .ROUND_K(rk8), .ROUND_Q(rq8),
    .BUSY(busy8), .DONE(done8), .D_OUT(dout8), .o_dbg_fsm(fsm8));

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [31:0] d, input logic [63:0] key,
                                            input int nr, input int kbytes);
    logic [31:0] s;
    logic [7:0]  k;
    s = d;
    for (int r = 0; r < nr; r++) begin
      k = 8'(key >> (8 * (r % kbytes)));
      s = {s[23:0], s[31:24]} ^ {24'h0, k};
    end
    return s;
  endfunction

  task automatic nclk;
    @(negedge clk);
  endtask

  // ---------------- scoreboards ----------------
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q16[$];
  logic [31:0] exp_q8[$];
  int  done_cnt1 = 0, done_cnt16 = 0, done_cnt8 = 0;
  logic prev_done1 = 1'b0, prev_done16 = 1'b0, prev_done8 = 1'b0;

  always @(negedge clk) begin
    if (done1) begin
      done_cnt1++;
      chk("done1_one_cycle", 64'(prev_done1), 64'd0);
      if (exp_q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL done1_unexpected actual=DONE expected=no_DONE dout=%h", dout1);
      end else begin
        chk("dout1", 64'(dout1), 64'(exp_q1.pop_front()));
      end
    end
    prev_done1 = done1;
  end

  always @(negedge clk) begin
    if (done16) begin
      done_cnt16++;
      chk("done16_one_cycle", 64'(prev_done16), 64'd0);
      if (exp_q16.size() == 0) begin
        checks++; failures++;
        $display("FAIL done16_unexpected actual=DONE expected=no_DONE dout=%h", dout16);
      end else begin
        chk("dout16", 64'(dout16), 64'(exp_q16.pop_front()));
      end
    end
    prev_done16 = done16;
  end

  always @(negedge clk) begin
    if (done8) begin
      done_cnt8++;
      chk("done8_one_cycle", 64'(prev_done8), 64'd0);
      if (exp_q8.size() == 0) begin
        checks++; failures++;
        $display("FAIL done8_unexpected actual=DONE expected=no_DONE dout=%h", dout8);
      end else begin
        chk("dout8", 64'(dout8), 64'(exp_q8.pop_front()));
      end
    end
    prev_done8 = done8;
  end

  // ---------------- 16-round drivers ----------------
  // Drives one block; poke re-asserts START with junk data mid-RUN and in FIN.
  task automatic run16(input logic [31:0] d, input logic [63:0] k, input logic [31:0] e,
                       input bit poke);
    start16 = 1'b1; d16 = d; k16 = k;
    exp_q16.push_back(e);
    nclk;
    start16 = 1'b0;
    for (int r = 0; r < 16; r++) begin
      chk("round_k16", 64'(rk16), 64'(8'(k >> (8 * (r % 8)))));
      chk("done16_early", 64'(done16), 64'd0);
      chk("busy16_run", 64'(busy16), 64'd1);
      start16 = poke && (r == 2);
      if (poke && r == 2) begin
        d16 = 32'hFFFF_FFFF; k16 = '1;
      end
      nclk;
    end
    chk("done16_at_last", 64'(done16), 64'd1);
    chk("fsm16_fin", 64'(fsm16), 64'(ST_FIN));
    chk("dout16_direct", 64'(dout16), 64'(e));
    if (poke) begin
      start16 = 1'b1; d16 = 32'hFFFF_FFFF; k16 = '1;
    end
    nclk;
    start16 = 1'b0;
    chk("done16_fall", 64'(done16), 64'd0);
    chk("busy16_fall", 64'(busy16), 64'd0);
    chk("fsm16_idle", 64'(fsm16), 64'(ST_IDLE));
    nclk;
    chk("busy16_not_queued", 64'(busy16), 64'd0);
    chk("dout16_after", 64'(dout16), 64'(e));
  endtask

  task automatic wait_done16(output int t);
    bit found;
    found = 1'b0;
    t = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      nclk;
      if (done16) begin
        found = 1'b1;
        t = cyc;
      end
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL wait_done16 actual=timeout expected=DONE within 40 cycles");
    end
  endtask

  typedef struct {
    logic [31:0] d_in;
    logic [63:0] key;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, saved_cnt;
    logic [31:0] e;
    logic [7:0]  key8;
    bit          found;

    vecs[0] = '{32'hDEAD_BEEF, 64'h0807_0605_0403_0201, 32'h0};
    vecs[1] = '{32'h0000_0000, 64'h0807_0605_0403_0201, 32'h0};
    vecs[2] = '{32'hFFFF_FFFF, 64'h0123_4567_89AB_CDEF, 32'h0};
    vecs[3] = '{32'hA5A5_5A5A, {$urandom, $urandom}, 32'h0};
    for (int i = 0; i < 4; i++) vecs[i].exp = ref_model(vecs[i].d_in, vecs[i].key, 16, 8);

    rst = 1'b1;
    start1 = 0; d1 = 0; k1 = 0;
    start16 = 0; d16 = 0; k16 = 0;
    start8 = 0; d8 = 0; k8 = 0;

    // Reset values
    nclk; nclk;
    chk("rst_busy16", 64'(busy16), 64'd0);
    chk("rst_done16", 64'(done16), 64'd0);
    chk("rst_dout16", 64'(dout16), 64'd0);
    chk("rst_round_d16", 64'(rd16), 64'd0);
    chk("rst_round_k16", 64'(rk16), 64'd0);
    chk("rst_fsm16", 64'(fsm16), 64'(ST_IDLE));
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_dout1", 64'(dout1), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_round_k8", 64'(rk8), 64'd0);
    rst = 1'b0;
    nclk;

    // Single round
    start1 = 1'b1; d1 = 32'h1234_5678; k1 = 64'h0807_0605_0403_0201;
    exp_q1.push_back(ref_model(d1, k1, 1, 8));
    nclk;
    start1 = 1'b0; d1 = 32'h0; k1 = '1;
    chk("single_busy_e0", 64'(busy1), 64'd1);
    chk("single_round_k", 64'(rk1), 64'h01);
    chk("single_fsm_run", 64'(fsm1), 64'(ST_RUN));
    chk("single_done_e0", 64'(done1), 64'd0);
    nclk;
    chk("single_done_e1", 64'(done1), 64'd1);
    chk("single_dout", 64'(dout1), 64'h3456_7813);
    chk("single_busy_e1", 64'(busy1), 64'd1);
    nclk;
    chk("single_done_e2", 64'(done1), 64'd0);
    chk("single_busy_e2", 64'(busy1), 64'd0);
    nclk;
    chk("single_busy_e3", 64'(busy1), 64'd0);

    // Table-driven 16-round blocks; after the first, D_OUT must hold while inputs churn
    for (int i = 0; i < 4; i++) begin
      run16(vecs[i].d_in, vecs[i].key, vecs[i].exp, 1'b0);
      if (i == 0) begin
        for (int c = 0; c < 20; c++) begin
          d16 = $urandom; k16 = {$urandom, $urandom};
          nclk;
          chk("dout16_hold", 64'(dout16), 64'(vecs[0].exp));
        end
      end
    end

    // START while busy is ignored
    run16(vecs[0].d_in, vecs[0].key, vecs[0].exp, 1'b1);

    // START held continuously: 18-cycle block period
    d16 = 32'hC0FF_EE11; k16 = vecs[0].key;
    e = ref_model(d16, k16, 16, 8);
    exp_q16.push_back(e);
    exp_q16.push_back(e);
    start16 = 1'b1;
    wait_done16(t1);
    nclk;
    chk("held_busy_gap", 64'(busy16), 64'd0);
    nclk;
    chk("held_reaccept", 64'(busy16), 64'd1);
    start16 = 1'b0;
    wait_done16(t2);
    chk("held_period", 64'(t2 - t1), 64'd18);
    nclk; nclk;

    // Reset mid-operation
    saved_cnt = done_cnt16;
    start16 = 1'b1; d16 = 32'h1357_9BDF; k16 = vecs[0].key;
    nclk;
    start16 = 1'b0;
    repeat (7) nclk;
    chk("midrst_busy_before", 64'(busy16), 64'd1);
    rst = 1'b1;
    nclk;
    rst = 1'b0;
    chk("midrst_fsm", 64'(fsm16), 64'(ST_IDLE));
    chk("midrst_busy", 64'(busy16), 64'd0);
    chk("midrst_done", 64'(done16), 64'd0);
    chk("midrst_dout", 64'(dout16), 64'd0);
    chk("midrst_round_d", 64'(rd16), 64'd0);
    repeat (20) nclk;
    chk("midrst_no_done", 64'(done_cnt16), 64'(saved_cnt));
    run16(vecs[2].d_in, vecs[2].key, vecs[2].exp, 1'b0);

    // 8-bit key, back-to-back blocks
    for (int b = 0; b < 2; b++) begin
      d8 = (b == 0) ? 32'h89AB_CDEF : 32'h0F1E_2D3C;
      key8 = (b == 0) ? 8'h5A : 8'hC3;
      k8 = key8;
      exp_q8.push_back(ref_model(d8, {56'h0, key8}, 5, 1));
      start8 = 1'b1;
      nclk;
      start8 = 1'b0; k8 = ~key8; d8 = '0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        if (!busy8) found = 1'b1;
        else begin
          chk("round_k8", 64'(rk8), 64'(key8));
          nclk;
        end
      end
      if (!found) begin
        checks++; failures++;
        $display("FAIL kw8_busy actual=stuck_busy expected=idle within 10 cycles");
      end
    end
    repeat (3) nclk;

    chk("done_cnt1", 64'(done_cnt1), 64'd1);
    chk("done_cnt16", 64'(done_cnt16), 64'd8);
    chk("done_cnt8", 64'(done_cnt8), 64'd2);
    chk("q1_empty", 64'(exp_q1.size()), 64'd0);
    chk("q16_empty", 64'(exp_q16.size()), 64'd0);
    chk("q8_empty", 64'(exp_q8.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

- Iterative sequencer for the 32-bit/8-bit-key round datapath in the post-processing chain.
- Accepts a 32-bit block and a round-key vector, then drives the external combinational round function for NUM_ROUNDS iterations, one round per cycle, feeding each round output back as the next round input.
- Supplies a rotating 8-bit round key, counts rounds, and on completion presents the result with a one-cycle DONE pulse.
- Sits between the raw-bit collector (block source) and the output buffer (result sink).

## Interface

Parameters:
- NUM_ROUNDS, 16: rounds per block; legal range 1..255.
- KEY_WIDTH, 64: width of KEY; must be a multiple of 8 and at least 8.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  block request; sampled only in IDLE.
- D_IN  input  32  plaintext block, captured when START is accepted.
- KEY  input  KEY_WIDTH  round-key vector, captured when START is accepted.
- ROUND_D  output  32  round-function data input (the internal state register).
- ROUND_K  output  8  round-function key input; equals key_reg[7:0].
- ROUND_Q  input  32  round-function output; combinational function of ROUND_D and ROUND_K.
- BUSY  output  1  high from START acceptance until return to IDLE.
- DONE  output  1  one-cycle pulse; D_OUT is valid and new in this cycle.
- D_OUT  output  32  last completed result; held until the next completion.

## Operation

Internal registers:
- state_reg, 32 bits; drives ROUND_D.
- key_reg, KEY_WIDTH bits.
- cnt, 8 bits.
- fsm, one of IDLE, RUN, FIN.

IDLE:
- BUSY=0.
- If START=1: state_reg<=D_IN, key_reg<=KEY, cnt<=0, go to RUN.
- START=0: all registers hold.

RUN (each cycle):
- state_reg<=ROUND_Q.
- key_reg<=key_reg rotated right by 8, so ROUND_K for round r is byte (r mod KEY_WIDTH/8) of KEY, with byte 0 = KEY[7:0].
- cnt<=cnt+1.
- When cnt==NUM_ROUNDS-1: D_OUT<=ROUND_Q, DONE<=1, go to FIN.

FIN:
- DONE=1 for exactly this cycle.
- Next edge: DONE<=0, go to IDLE.

START handling outside IDLE:
- START in RUN or FIN is ignored. It is not queued and D_IN/KEY are not sampled.
- The requester must hold or re-assert START after BUSY falls.

D_OUT is written only on the final round edge. Between completions it holds its value regardless of D_IN, KEY or START.

Reset:
- RST=1 has priority over every transition, including mid-RUN and in FIN.
- On reset: fsm=IDLE, state_reg=0, key_reg=0, cnt=0, D_OUT=0, DONE=0, BUSY=0.
- Therefore ROUND_D=0 and ROUND_K=0.
- An interrupted block is discarded and produces no DONE.

NUM_ROUNDS=1: RUN lasts one cycle and the first RUN edge is also the final edge.

## Timing

- Edge E0 samples START=1 in IDLE. BUSY=1 after E0.
- Rounds are executed on edges E1..E_N, where N=NUM_ROUNDS.
- DONE=1 and the new D_OUT are visible after E_N.
- DONE falls and BUSY falls after E_(N+1).
- Earliest next acceptance is edge E_(N+1) only if START is sampled in IDLE; fsm reaches IDLE after E_(N+1), so acceptance occurs at E_(N+2). Block period is N+2 cycles.
- Round path is CLK → state_reg → external round function → state_reg. There are no other combinational paths from inputs to outputs.
- BUSY, DONE, D_OUT, ROUND_D and ROUND_K are all registered or derived only from registers.

## Test plan

Bench round model: ROUND_Q = {ROUND_D[23:0], ROUND_D[31:24]} ^ {24'h0, ROUND_K}.

- Reset value check: assert RST for 2 cycles → BUSY=0, DONE=0, D_OUT=0, ROUND_D=0, ROUND_K=0.
- Single round: NUM_ROUNDS=1, D_IN=32'h12345678, KEY=64'h0807060504030201, START pulse.
  - ROUND_K=8'h01 during RUN.
  - DONE high exactly 1 cycle, 2 cycles after E0.
  - D_OUT=32'h34567813.
  - BUSY high for exactly 2 cycles.
- Key rotation and latency: NUM_ROUNDS=16, same KEY, D_IN=32'hDEADBEEF.
  - ROUND_K sequence over the 16 RUN cycles is 01..08, 01..08.
  - DONE comes 17 cycles after E0.
  - D_OUT matches the reference model.
  - D_OUT holds through 20 idle cycles while D_IN toggles.
- START while busy: re-pulse START with D_IN=32'hFFFFFFFF at cycles 3 and in FIN → ignored, first result unchanged. START held high continuously → new block accepted 2 cycles after DONE, period 18 cycles.
- Reset mid-operation: RST at round 7 of 16 → no DONE, D_OUT=0, fsm IDLE next cycle. A subsequent START completes normally with correct D_OUT.
- Back-to-back blocks with KEY_WIDTH=8: every round key equals KEY[7:0]. Two consecutive blocks give correct, independent D_OUT values with one DONE each.
